// File: rtl/adda_cfg_pkg.sv
// ----------------------------------------------------------------------------
// adda_cfg_pkg
// Shared definitions for the ADC/DAC configuration sequencer:
//   - sequencer state encoding
//   - SPI frame width
//   - cfg_entry(): the fixed register table, {addr[6:0], data[7:0]} per index
// ----------------------------------------------------------------------------
package adda_cfg_pkg;

    localparam int FRAME_W = 16;

    typedef enum logic [2:0] {
        ST_WAIT  = 3'd0,
        ST_WR    = 3'd1,
        ST_GAP   = 3'd2,
        ST_RD    = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } cfg_state_t;

    // Register table: {addr[6:0], data[7:0]} for each table index.
    function automatic logic [14:0] cfg_entry(input logic [2:0] idx);
        logic [14:0] entry;
        case (idx)
            3'd0:    entry = {7'h00, 8'h80};
            3'd1:    entry = {7'h01, 8'h03};
            3'd2:    entry = {7'h02, 8'h00};
            3'd3:    entry = {7'h08, 8'h1F};
            3'd4:    entry = {7'h09, 8'h1F};
            3'd5:    entry = {7'h14, 8'h41};
            3'd6:    entry = {7'h15, 8'h00};
            3'd7:    entry = {7'h3F, 8'h01};
            default: entry = {7'h00, 8'h00};
        endcase
        return entry;
    endfunction

endpackage

// File: rtl/adda_cfg_seq_spi_frame_xfer.sv
// ----------------------------------------------------------------------------
// spi_frame_xfer
// One 16-bit SPI mode-0 frame per start pulse. The frame is 34 phases of
// CLK_DIV clocks each: a setup phase (CSN low, SCLK low, bit15 on MOSI),
// 32 alternating SCLK high/low phases (16 rising edges), and a hold phase
// before CSN rises, so CSN is low for exactly 34*CLK_DIV clocks.
// MOSI advances on every SCLK fall; MISO is shifted in on rising edges 9..16.
// Ports:
//   clock, reset     system clock, async active-low reset
//   start            1-cycle request, ignored while a frame is in progress
//   tx_word[15:0]    frame to send, MSB first
//   spi_csn/sclk/mosi registered SPI outputs
//   spi_miso         serial input
//   rx_byte[7:0]     byte captured during the last frame
//   done             1-cycle pulse in the cycle after CSN rises
// ----------------------------------------------------------------------------
module spi_frame_xfer
    import adda_cfg_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [FRAME_W-1:0] tx_word,
    output logic               spi_csn,
    output logic               spi_sclk,
    output logic               spi_mosi,
    input  logic               spi_miso,
    output logic [7:0]         rx_byte,
    output logic               done
);

    localparam int DIV_W = $clog2(CLK_DIV);

    logic               active_r;
    logic [5:0]         phase_r;
    logic [DIV_W-1:0]   div_r;
    logic [FRAME_W-1:0] shift_r;
    logic [7:0]         rx_r;
    logic               csn_r;
    logic               sclk_r;
    logic               mosi_r;
    logic               done_r;

    // Frame engine: phase/divider counters and all registered SPI outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            active_r <= 1'b0;
            phase_r  <= 6'd0;
            div_r    <= {DIV_W{1'b0}};
            shift_r  <= {FRAME_W{1'b0}};
            rx_r     <= 8'h00;
            csn_r    <= 1'b1;
            sclk_r   <= 1'b0;
            mosi_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (!active_r) begin
                if (start) begin
                    active_r <= 1'b1;
                    csn_r    <= 1'b0;
                    sclk_r   <= 1'b0;
                    mosi_r   <= tx_word[FRAME_W-1];
                    shift_r  <= {tx_word[FRAME_W-2:0], 1'b0};
                    phase_r  <= 6'd0;
                    div_r    <= {DIV_W{1'b0}};
                end else begin
                    active_r <= 1'b0;
                end
            end else if (div_r != DIV_W'(CLK_DIV - 1)) begin
                div_r <= div_r + DIV_W'(1);
            end else begin
                div_r <= {DIV_W{1'b0}};
                if (phase_r == 6'd33) begin
                    // End of hold phase: release the slave.
                    active_r <= 1'b0;
                    csn_r    <= 1'b1;
                    mosi_r   <= 1'b0;
                    phase_r  <= 6'd0;
                    done_r   <= 1'b1;
                end else begin
                    phase_r <= phase_r + 6'd1;
                    if ((phase_r[0] == 1'b0) && (phase_r < 6'd32)) begin
                        // Entering an odd phase: rising edge number phase_r/2+1.
                        sclk_r <= 1'b1;
                        if (phase_r >= 6'd16) begin
                            rx_r <= {rx_r[6:0], spi_miso};
                        end else begin
                            rx_r <= rx_r;
                        end
                    end else if (phase_r[0] == 1'b1) begin
                        // Entering an even phase: falling edge, next bit out.
                        sclk_r  <= 1'b0;
                        mosi_r  <= shift_r[FRAME_W-1];
                        shift_r <= {shift_r[FRAME_W-2:0], 1'b0};
                    end else begin
                        // Phase 32 -> 33 is the CSN hold time; nothing moves.
                        sclk_r <= 1'b0;
                    end
                end
            end
        end
    end

    assign spi_csn  = csn_r;
    assign spi_sclk = sclk_r;
    assign spi_mosi = mosi_r;
    assign rx_byte  = rx_r;
    assign done     = done_r;

endmodule

// File: rtl/adda_cfg_seq.sv
// ----------------------------------------------------------------------------
// adda_cfg_seq
// Post-reset configuration sequencer for the ADC/DAC front end. After a
// settle delay it writes every entry of the register table over SPI, then
// reads each entry back and compares. Ends in DONE (cfg_done) or ERROR
// (cfg_err with the first failing index and the byte read back).
// Ports:
//   clock, reset      system clock, async active-low reset
//   restart           1-cycle pulse, reruns the sequence from DONE/ERROR
//   spi_csn/sclk/mosi SPI master outputs (mode 0, MSB first)
//   spi_miso          SPI input
//   busy              high until DONE or ERROR
//   cfg_done          all entries written and verified
//   cfg_err           readback mismatch
//   err_index/data    index and byte of the first mismatch
// ----------------------------------------------------------------------------
module adda_cfg_seq
    import adda_cfg_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int N_REGS    = 8,
    parameter int START_DLY = 1000,
    parameter int GAP_CLKS  = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       restart,
    output logic       spi_csn,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       busy,
    output logic       cfg_done,
    output logic       cfg_err,
    output logic [2:0] err_index,
    output logic [7:0] err_data
);

    localparam int CNT_W = 16;

    cfg_state_t         state_r, state_s;
    logic [2:0]         idx_r, idx_s;
    logic               rd_phase_r, rd_phase_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic               err_r, err_s;
    logic [2:0]         err_index_r, err_index_s;
    logic [7:0]         err_data_r, err_data_s;
    logic               start_s;
    logic [14:0]        cur_entry_s;
    logic [14:0]        next_entry_s;
    logic [FRAME_W-1:0] tx_word_s;
    logic               xfer_done_s;
    logic [7:0]         rx_byte_s;

    spi_frame_xfer #(
        .CLK_DIV (CLK_DIV)
    ) u_xfer (
        .clock    (clock),
        .reset    (reset),
        .start    (start_s),
        .tx_word  (tx_word_s),
        .spi_csn  (spi_csn),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .rx_byte  (rx_byte_s),
        .done     (xfer_done_s)
    );

    // Sequencer next-state, frame launch and next values of the status outputs.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        rd_phase_s  = rd_phase_r;
        cnt_s       = cnt_r;
        busy_s      = busy_r;
        done_s      = done_r;
        err_s       = err_r;
        err_index_s = err_index_r;
        err_data_s  = err_data_r;
        start_s     = 1'b0;
        cur_entry_s = cfg_entry(idx_r);

        case (state_r)
            ST_WAIT: begin
                if (cnt_r == CNT_W'(START_DLY - 1)) begin
                    start_s    = 1'b1;
                    state_s    = ST_WR;
                    idx_s      = 3'd0;
                    rd_phase_s = 1'b0;
                    cnt_s      = {CNT_W{1'b0}};
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_GAP: begin
                // The GAP state is entered one clock after CSN rises, so the
                // launch comes GAP_CLKS-2 counts later to give GAP_CLKS high clocks.
                if (cnt_r == CNT_W'(GAP_CLKS - 2)) begin
                    start_s = 1'b1;
                    state_s = rd_phase_r ? ST_RD : ST_WR;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_WR: begin
                if (xfer_done_s) begin
                    state_s = ST_GAP;
                    cnt_s   = {CNT_W{1'b0}};
                    if (idx_r == 3'(N_REGS - 1)) begin
                        idx_s      = 3'd0;
                        rd_phase_s = 1'b1;
                    end else begin
                        idx_s = idx_r + 3'd1;
                    end
                end else begin
                    state_s = ST_WR;
                end
            end
            ST_RD: begin
                if (xfer_done_s) begin
                    // Only the data half is really compared; the address half
                    // is substituted from the table so both sides share it.
                    if ({cur_entry_s[14:8], rx_byte_s} != cur_entry_s) begin
                        state_s     = ST_ERROR;
                        busy_s      = 1'b0;
                        err_s       = 1'b1;
                        err_index_s = idx_r;
                        err_data_s  = rx_byte_s;
                    end else if (idx_r == 3'(N_REGS - 1)) begin
                        state_s = ST_DONE;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                    end else begin
                        state_s = ST_GAP;
                        idx_s   = idx_r + 3'd1;
                        cnt_s   = {CNT_W{1'b0}};
                    end
                end else begin
                    state_s = ST_RD;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (restart) begin
                    state_s     = ST_WAIT;
                    cnt_s       = {CNT_W{1'b0}};
                    idx_s       = 3'd0;
                    rd_phase_s  = 1'b0;
                    busy_s      = 1'b1;
                    done_s      = 1'b0;
                    err_s       = 1'b0;
                    err_index_s = 3'd0;
                    err_data_s  = 8'h00;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = ST_WAIT;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase

        // Frame word for the launch happening this cycle (uses next index).
        next_entry_s = cfg_entry(idx_s);
        tx_word_s    = {rd_phase_s, next_entry_s[14:8], rd_phase_s ? 8'h00 : next_entry_s[7:0]};
    end

    // Sequencer state and registered status outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_WAIT;
            idx_r       <= 3'd0;
            rd_phase_r  <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            err_index_r <= 3'd0;
            err_data_r  <= 8'h00;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            rd_phase_r  <= rd_phase_s;
            cnt_r       <= cnt_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            err_r       <= err_s;
            err_index_r <= err_index_s;
            err_data_r  <= err_data_s;
        end
    end

    assign busy      = busy_r;
    assign cfg_done  = done_r;
    assign cfg_err   = err_r;
    assign err_index = err_index_r;
    assign err_data  = err_data_r;

endmodule

// File: tb/tb_adda_cfg_seq.sv
// ----------------------------------------------------------------------------
// tb_adda_cfg_seq
// Scoreboard bench for adda_cfg_seq. The stimulus process pushes the
// expected frame list and final outcome for each sequence; a SPI slave model
// echoes written bytes back on reads (optionally corrupting one address);
// a monitor decodes every SPI frame and completion event and compares.
// ----------------------------------------------------------------------------
module tb_adda_cfg_seq;

    localparam int CLK_DIV    = 4;
    localparam int N_REGS     = 8;
    localparam int START_DLY  = 1000;
    localparam int GAP_CLKS   = 8;
    localparam int FRAME_CLKS = 34 * CLK_DIV;

    logic       clock   = 1'b0;
    logic       reset   = 1'b0;
    logic       restart = 1'b0;
    logic       spi_miso = 1'b0;
    logic       spi_csn, spi_sclk, spi_mosi;
    logic       busy, cfg_done, cfg_err;
    logic [2:0] err_index;
    logic [7:0] err_data;

    adda_cfg_seq #(
        .CLK_DIV   (CLK_DIV),
        .N_REGS    (N_REGS),
        .START_DLY (START_DLY),
        .GAP_CLKS  (GAP_CLKS)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .restart   (restart),
        .spi_csn   (spi_csn),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .busy      (busy),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .err_index (err_index),
        .err_data  (err_data)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference register table.
    logic [6:0] tbl_addr [8] = '{7'h00, 7'h01, 7'h02, 7'h08, 7'h09, 7'h14, 7'h15, 7'h3F};
    logic [7:0] tbl_data [8] = '{8'h80, 8'h03, 8'h00, 8'h1F, 8'h1F, 8'h41, 8'h00, 8'h01};

    typedef struct { logic [15:0] word; int abs_fall; } frame_exp_t;
    typedef struct { logic is_err; logic [2:0] idx; logic [7:0] data; } done_exp_t;

    frame_exp_t  exp_q[$];
    done_exp_t   cmp_q[$];
    logic [15:0] seen_words[$];
    int          frames_seen = 0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: whole sequence outcome from the table and the slave's readback.
    task automatic push_seq(input int abs_fall, input bit bad, input int bad_idx, input logic [7:0] bad_val);
        frame_exp_t f;
        done_exp_t  d;
        for (int i = 0; i < N_REGS; i++) begin
            f.word     = {1'b0, tbl_addr[i], tbl_data[i]};
            f.abs_fall = (i == 0) ? abs_fall : -1;
            exp_q.push_back(f);
        end
        for (int i = 0; i < N_REGS; i++) begin
            logic [7:0] back;
            f.word     = {1'b1, tbl_addr[i], 8'h00};
            f.abs_fall = -1;
            exp_q.push_back(f);
            back = (bad && i == bad_idx) ? bad_val : tbl_data[i];
            if (back != tbl_data[i]) begin
                d.is_err = 1'b1; d.idx = 3'(i); d.data = back;
                cmp_q.push_back(d);
                return;
            end
        end
        d.is_err = 1'b0; d.idx = 3'd0; d.data = 8'h00;
        cmp_q.push_back(d);
    endtask

    // SPI slave model: echoes writes, one address may be forced to a bad value.
    bit         ovr_en   = 1'b0;
    logic [6:0] ovr_addr = 7'h00;
    logic [7:0] ovr_val  = 8'h00;
    logic [7:0] mem [128];
    bit         s_prev_sclk = 1'b0;
    bit         s_rw = 1'b0;
    int         s_cnt = 0;
    logic [15:0] s_shift = 16'h0000;
    logic [7:0] s_rd = 8'h00;

    initial for (int i = 0; i < 128; i++) mem[i] = 8'h00;

    always @(negedge clock) begin
        if (!reset || spi_csn) begin
            s_cnt    = 0;
            s_rw     = 1'b0;
            spi_miso = 1'b0;
        end else if (spi_sclk && !s_prev_sclk) begin
            s_shift = {s_shift[14:0], spi_mosi};
            s_cnt++;
            if (s_cnt == 8) begin
                s_rw = s_shift[7];
                s_rd = (ovr_en && s_shift[6:0] == ovr_addr) ? ovr_val : mem[s_shift[6:0]];
            end
            if (s_cnt == 16 && !s_shift[15]) mem[s_shift[14:8]] = s_shift[7:0];
        end else if (!spi_sclk && s_prev_sclk && s_rw && s_cnt >= 8 && s_cnt < 16) begin
            spi_miso = s_rd[15 - s_cnt];
        end
        s_prev_sclk = spi_sclk;
    end

    // Monitor: decode frames and completion events, compare against the queues.
    bit          m_prev_csn = 1'b1, m_prev_sclk = 1'b0, m_prev_done = 1'b0, m_prev_err = 1'b0;
    bit          m_in_frame = 1'b0;
    int          m_fall = 0, m_last_rise = 0, m_rises = 0;
    logic [15:0] m_word = 16'h0000;
    frame_exp_t  m_cur;
    done_exp_t   m_d;

    always @(negedge clock) begin
        if (!reset) begin
            m_in_frame  = 1'b0;
            m_prev_csn  = 1'b1;
            m_prev_sclk = 1'b0;
            m_prev_done = 1'b0;
            m_prev_err  = 1'b0;
        end else begin
            if (m_prev_csn && !spi_csn) begin
                frames_seen++;
                chk("frame_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    m_cur      = exp_q.pop_front();
                    m_in_frame = 1'b1;
                    m_fall     = cyc;
                    m_rises    = 0;
                    m_word     = 16'h0000;
                    if (m_cur.abs_fall >= 0) chk("first_fall_cycle", cyc, m_cur.abs_fall);
                    else chk("gap_clks", cyc - m_last_rise, GAP_CLKS);
                end
            end
            if (m_in_frame && spi_sclk && !m_prev_sclk) begin
                m_rises++;
                m_word = {m_word[14:0], spi_mosi};
            end
            if (!m_prev_csn && spi_csn) begin
                m_last_rise = cyc;
                if (m_in_frame) begin
                    chk("frame_len", cyc - m_fall, FRAME_CLKS);
                    chk("sclk_rises", m_rises, 16);
                    chk("frame_word", m_word, m_cur.word);
                    seen_words.push_back(m_word);
                    m_in_frame = 1'b0;
                end
            end
            if ((cfg_done && !m_prev_done) || (cfg_err && !m_prev_err)) begin
                chk("completion_expected", int'(cmp_q.size() > 0), 1);
                if (cmp_q.size() > 0) begin
                    m_d = cmp_q.pop_front();
                    chk("cfg_err_level", cfg_err, m_d.is_err);
                    chk("cfg_done_level", cfg_done, !m_d.is_err);
                    chk("busy_at_end", busy, 0);
                    chk("end_timing", cyc - m_last_rise, 1);
                    if (m_d.is_err) begin
                        chk("err_index", err_index, m_d.idx);
                        chk("err_data", err_data, m_d.data);
                    end
                end
            end
            m_prev_csn  = spi_csn;
            m_prev_sclk = spi_sclk;
            m_prev_done = cfg_done;
            m_prev_err  = cfg_err;
        end
    end

    task automatic wait_idle(input int limit);
        int t = 0;
        while ((exp_q.size() != 0 || cmp_q.size() != 0) && t < limit) begin
            @(negedge clock);
            t++;
        end
        chk("seq_pending", exp_q.size() + cmp_q.size(), 0);
        exp_q.delete();
        cmp_q.delete();
    endtask

    task automatic do_restart(input bit bad, input int bad_idx, input logic [7:0] bad_val);
        @(negedge clock);
        ovr_en   = bad;
        ovr_addr = tbl_addr[bad_idx];
        ovr_val  = bad_val;
        push_seq(cyc + START_DLY + 1, bad, bad_idx, bad_val);
        restart = 1'b1;
        @(negedge clock);
        restart = 1'b0;
        chk("restart_clr_done", cfg_done, 0);
        chk("restart_clr_err", cfg_err, 0);
        chk("restart_busy", busy, 1);
        chk("restart_clr_eidx", err_index, 0);
        chk("restart_clr_edata", err_data, 0);
    endtask

    initial begin
        int t;
        int n;
        int j;
        logic [7:0] mask;

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_csn", spi_csn, 1);
        chk("rst_sclk", spi_sclk, 0);
        chk("rst_mosi", spi_mosi, 0);
        chk("rst_busy", busy, 1);
        chk("rst_done", cfg_done, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_eidx", err_index, 0);
        chk("rst_edata", err_data, 0);

        // Normal run; restart coincident with release and mid write frame are ignored
        @(negedge clock);
        push_seq(cyc + START_DLY, 1'b0, 0, 8'h00);
        reset   = 1'b1;
        restart = 1'b1;
        @(negedge clock);
        restart = 1'b0;
        t = 0;
        while (!(frames_seen >= 3 && !spi_csn) && t < 5000) begin
            @(negedge clock);
            t++;
        end
        chk("reach_write_frame2", int'(t < 5000), 1);
        repeat ($urandom_range(1, 100)) @(negedge clock);
        restart = 1'b1;
        @(negedge clock);
        restart = 1'b0;
        wait_idle(6000);
        chk("idx3_write_word", seen_words.size() > 3 ? int'(seen_words[3]) : -1, 16'h081F);
        chk("done_hold", cfg_done, 1);

        // Readback of addr 08 returns 0x1E -> error at index 3, no more frames
        do_restart(1'b1, 3, 8'h1E);
        wait_idle(6000);
        n = frames_seen;
        repeat (400) @(negedge clock);
        chk("no_frames_after_err", frames_seen, n);
        chk("err_hold", cfg_err, 1);
        chk("err_hold_idx", err_index, 3);
        chk("err_hold_data", err_data, 8'h1E);
        chk("err_busy", busy, 0);

        // Fixed slave, restart from ERROR
        do_restart(1'b0, 0, 8'h00);
        wait_idle(6000);
        chk("done_after_fix", cfg_done, 1);

        // Random single-bit corruption at a random index
        for (int k = 0; k < 3; k++) begin
            j    = $urandom_range(0, N_REGS - 1);
            mask = 8'h01 << $urandom_range(0, 7);
            do_restart(1'b1, j, tbl_data[j] ^ mask);
            wait_idle(6000);
        end

        // Reset while SCLK is high in frame 5 of a fresh sequence
        n = frames_seen;
        do_restart(1'b0, 0, 8'h00);
        t = 0;
        while (!(frames_seen == n + 6 && !spi_csn && spi_sclk) && t < 5000) begin
            @(negedge clock);
            t++;
        end
        chk("reach_frame5_sclk_high", int'(t < 5000), 1);
        #1 reset = 1'b0;
        #1;
        chk("abort_csn", spi_csn, 1);
        chk("abort_sclk", spi_sclk, 0);
        chk("abort_busy", busy, 1);
        exp_q.delete();
        cmp_q.delete();
        repeat (5) @(negedge clock);
        push_seq(cyc + START_DLY, 1'b0, 0, 8'h00);
        reset = 1'b1;
        wait_idle(6000);
        chk("done_after_abort", cfg_done, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
